// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, operand-type codes
// and the decoded micro-op structure used by decode_comb and decode_stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU_NOP must stay zero so an all-zero uop is a harmless bubble
    localparam logic [5:0] ALU_NOP    = 6'd0;
    localparam logic [5:0] ALU_ADD    = 6'd1;
    localparam logic [5:0] ALU_SUB    = 6'd2;
    localparam logic [5:0] ALU_SLL    = 6'd3;
    localparam logic [5:0] ALU_SLT    = 6'd4;
    localparam logic [5:0] ALU_SLTU   = 6'd5;
    localparam logic [5:0] ALU_XOR    = 6'd6;
    localparam logic [5:0] ALU_SRL    = 6'd7;
    localparam logic [5:0] ALU_SRA    = 6'd8;
    localparam logic [5:0] ALU_OR     = 6'd9;
    localparam logic [5:0] ALU_AND    = 6'd10;
    localparam logic [5:0] ALU_LUI    = 6'd11;
    localparam logic [5:0] ALU_JAL    = 6'd12;
    localparam logic [5:0] ALU_JALR   = 6'd13;
    localparam logic [5:0] ALU_BEQ    = 6'd14;
    localparam logic [5:0] ALU_BNE    = 6'd15;
    localparam logic [5:0] ALU_BLT    = 6'd16;
    localparam logic [5:0] ALU_BGE    = 6'd17;
    localparam logic [5:0] ALU_BLTU   = 6'd18;
    localparam logic [5:0] ALU_BGEU   = 6'd19;
    localparam logic [5:0] ALU_MUL    = 6'd20;
    localparam logic [5:0] ALU_MULH   = 6'd21;
    localparam logic [5:0] ALU_MULHSU = 6'd22;
    localparam logic [5:0] ALU_MULHU  = 6'd23;
    localparam logic [5:0] ALU_DIV    = 6'd24;
    localparam logic [5:0] ALU_DIVU   = 6'd25;
    localparam logic [5:0] ALU_REM    = 6'd26;
    localparam logic [5:0] ALU_REMU   = 6'd27;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  alucode;
        logic [1:0]  aluop1_type;
        logic [1:0]  aluop2_type;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        is_halt;
    } uop_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: raw instruction -> uop_t + illegal flag.
// Optional feature macro: RV32M_EN (adds the OP funct7=0000001 M-extension codes).
module decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output uop_t        uop,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    // Decode by opcode; any bad field sets 'bad', which scrubs control bits at the end
    always_comb begin
        logic bad;
        bad = 1'b0;
        uop = '0;
        uop.rs1 = inst[19:15];
        uop.rs2 = inst[24:20];
        uop.rd  = inst[11:7];
        case (opcode)
            OPC_OP: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_REG;
                uop.reg_we      = ENABLE;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  uop.alucode = ALU_ADD;
                        3'b001:  uop.alucode = ALU_SLL;
                        3'b010:  uop.alucode = ALU_SLT;
                        3'b011:  uop.alucode = ALU_SLTU;
                        3'b100:  uop.alucode = ALU_XOR;
                        3'b101:  uop.alucode = ALU_SRL;
                        3'b110:  uop.alucode = ALU_OR;
                        default: uop.alucode = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      uop.alucode = ALU_SUB;
                    else if (funct3 == 3'b101) uop.alucode = ALU_SRA;
                    else                       bad = 1'b1;
`ifdef RV32M_EN
                end else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000:  uop.alucode = ALU_MUL;
                        3'b001:  uop.alucode = ALU_MULH;
                        3'b010:  uop.alucode = ALU_MULHSU;
                        3'b011:  uop.alucode = ALU_MULHU;
                        3'b100:  uop.alucode = ALU_DIV;
                        3'b101:  uop.alucode = ALU_DIVU;
                        3'b110:  uop.alucode = ALU_REM;
                        default: uop.alucode = ALU_REMU;
                    endcase
`else
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.reg_we      = ENABLE;
                uop.imm         = imm_i;
                case (funct3)
                    3'b000: uop.alucode = ALU_ADD;
                    3'b010: uop.alucode = ALU_SLT;
                    3'b011: uop.alucode = ALU_SLTU;
                    3'b100: uop.alucode = ALU_XOR;
                    3'b110: uop.alucode = ALU_OR;
                    3'b111: uop.alucode = ALU_AND;
                    3'b001: begin
                        uop.imm = imm_sh;
                        if (funct7 == 7'b0000000) uop.alucode = ALU_SLL;
                        else                      bad = 1'b1;
                    end
                    default: begin
                        uop.imm = imm_sh;
                        if (funct7 == 7'b0000000)      uop.alucode = ALU_SRL;
                        else if (funct7 == 7'b0100000) uop.alucode = ALU_SRA;
                        else                           bad = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_u;
                uop.alucode     = ALU_LUI;
                uop.reg_we      = ENABLE;
            end
            OPC_AUIPC: begin
                uop.aluop1_type = OP_TYPE_PC;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_u;
                uop.alucode     = ALU_ADD;
                uop.reg_we      = ENABLE;
            end
            OPC_JAL: begin
                uop.aluop1_type = OP_TYPE_PC;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_j;
                uop.alucode     = ALU_JAL;
                uop.reg_we      = ENABLE;
            end
            OPC_JALR: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_i;
                uop.alucode     = ALU_JALR;
                uop.reg_we      = ENABLE;
                bad             = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_REG;
                uop.imm         = imm_b;
                uop.rd          = 5'd0;
                case (funct3)
                    3'b000:  uop.alucode = ALU_BEQ;
                    3'b001:  uop.alucode = ALU_BNE;
                    3'b100:  uop.alucode = ALU_BLT;
                    3'b101:  uop.alucode = ALU_BGE;
                    3'b110:  uop.alucode = ALU_BLTU;
                    3'b111:  uop.alucode = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_i;
                uop.alucode     = ALU_ADD;
                uop.is_load     = ENABLE;
                uop.reg_we      = ENABLE;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                uop.aluop1_type = OP_TYPE_REG;
                uop.aluop2_type = OP_TYPE_IMM;
                uop.imm         = imm_s;
                uop.alucode     = ALU_ADD;
                uop.is_store    = ENABLE;
                uop.rd          = 5'd0;
                bad = (funct3 > 3'b010);
            end
            OPC_SYSTEM: begin
                // Only ECALL / EBREAK are recognised; both stop the stage
                uop.rd = 5'd0;
                if (inst[31:7] == 25'd0 || inst[31:7] == {12'h001, 13'd0})
                    uop.is_halt = ENABLE;
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            uop.alucode     = ALU_NOP;
            uop.aluop1_type = OP_TYPE_NONE;
            uop.aluop2_type = OP_TYPE_NONE;
            uop.imm         = '0;
            uop.reg_we      = DISABLE;
            uop.is_load     = DISABLE;
            uop.is_store    = DISABLE;
            uop.is_halt     = DISABLE;
        end
        // Writes to x0 are never architecturally visible
        if (uop.rd == 5'd0)
            uop.reg_we = DISABLE;
        illegal = bad;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: circular instruction FIFO feeding one registered decoded uop,
// with a RUN/HALT state that freezes the stage after ECALL/EBREAK until flush.
// Optional feature macro: RV32M_EN (passed through to decode_comb).
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output uop_t                   out_uop,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t          state;
    logic [31:0]     inst_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    uop_t            dec_uop;
    logic            dec_illegal;
    logic            push, load;

    decode_comb u_dec (
        .inst    (inst_mem[rd_ptr]),
        .uop     (dec_uop),
        .illegal (dec_illegal)
    );

    assign in_ready = (count < FULL) && !flush && (state == RUN);
    assign push     = in_valid && in_ready;
    // Head moves into the output register whenever that register is free or draining
    assign load     = (state == RUN) && (count != '0) && (!out_valid || out_ready);

    // FIFO storage; contents are don't-care until written so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // FIFO pointers and occupancy; flush wins over any push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register and RUN/HALT control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            out_valid   <= 1'b0;
            out_uop     <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= RUN;
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_uop     <= dec_uop;
            out_pc      <= pc_mem[rd_ptr];
            out_illegal <= dec_illegal;
            if (dec_uop.is_halt) state <= HALT;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of decode vectors plus hand-written
// sequences for latency, back-pressure, halt, flush and mid-run reset.
module tb_decode_stage;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready;
    logic [31:0]            in_inst;
    logic [PC_W-1:0]        in_pc;
    logic                   flush;
    logic                   out_valid, out_ready;
    uop_t                   out_uop;
    logic [PC_W-1:0]        out_pc;
    logic                   out_illegal;
    logic [$clog2(DEPTH):0] count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_uop(out_uop), .out_pc(out_pc),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [1:0]  op1, op2;
        logic        we, ld, st, ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [31:0] i, logic [5:0] a, logic [31:0] im,
                                logic [4:0] rd, logic [1:0] o1, logic [1:0] o2,
                                logic we, logic ld, logic st, logic ill);
        vec_t v;
        v.name = n; v.inst = i; v.alu = a; v.imm = im; v.rd = rd;
        v.op1 = o1; v.op2 = o2; v.we = we; v.ld = ld; v.st = st; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Offer one instruction and hold it until accepted (bounded); called just after a rising edge
    task automatic push_hs(input logic [31:0] i, input logic [31:0] p, input string nm);
        bit done;
        done = 0;
        in_valid = 1'b1; in_inst = i; in_pc = p;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk({nm, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
    endtask

    task automatic check_vec(input vec_t v, input logic [31:0] p);
        chk({v.name, "_alu"},  out_uop.alucode,     v.alu);
        chk({v.name, "_imm"},  out_uop.imm,         v.imm);
        chk({v.name, "_rd"},   out_uop.rd,          v.rd);
        chk({v.name, "_op1"},  out_uop.aluop1_type, v.op1);
        chk({v.name, "_op2"},  out_uop.aluop2_type, v.op2);
        chk({v.name, "_we"},   out_uop.reg_we,      v.we);
        chk({v.name, "_ld"},   out_uop.is_load,     v.ld);
        chk({v.name, "_st"},   out_uop.is_store,    v.st);
        chk({v.name, "_ill"},  out_illegal,         v.ill);
        chk({v.name, "_pc"},   out_pc,              p);
    endtask

    initial begin
        bit ok;
        int got, extra;

        vecs.push_back(mk("add",    32'h002081B3, ALU_ADD, 32'h0,        5'd3, OP_TYPE_REG,  OP_TYPE_REG,  1, 0, 0, 0));
        vecs.push_back(mk("addi_x0",32'h00500013, ALU_ADD, 32'h5,        5'd0, OP_TYPE_REG,  OP_TYPE_IMM,  0, 0, 0, 0));
        vecs.push_back(mk("opc7f",  32'h0000007F, ALU_NOP, 32'h0,        5'd0, OP_TYPE_NONE, OP_TYPE_NONE, 0, 0, 0, 1));
        vecs.push_back(mk("sub",    32'h40628233, ALU_SUB, 32'h0,        5'd4, OP_TYPE_REG,  OP_TYPE_REG,  1, 0, 0, 0));
        vecs.push_back(mk("addi_m1",32'hFFF00093, ALU_ADD, 32'hFFFFFFFF, 5'd1, OP_TYPE_REG,  OP_TYPE_IMM,  1, 0, 0, 0));
        vecs.push_back(mk("srai31", 32'h41F1D113, ALU_SRA, 32'h1F,       5'd2, OP_TYPE_REG,  OP_TYPE_IMM,  1, 0, 0, 0));
        vecs.push_back(mk("lui",    32'h123452B7, ALU_LUI, 32'h12345000, 5'd5, OP_TYPE_NONE, OP_TYPE_IMM,  1, 0, 0, 0));
        vecs.push_back(mk("auipc",  32'h00001197, ALU_ADD, 32'h00001000, 5'd3, OP_TYPE_PC,   OP_TYPE_IMM,  1, 0, 0, 0));
        vecs.push_back(mk("lw",     32'hFFC12303, ALU_ADD, 32'hFFFFFFFC, 5'd6, OP_TYPE_REG,  OP_TYPE_IMM,  1, 1, 0, 0));
        vecs.push_back(mk("sw",     32'h0070A423, ALU_ADD, 32'h8,        5'd0, OP_TYPE_REG,  OP_TYPE_IMM,  0, 0, 1, 0));
        vecs.push_back(mk("beq",    32'hFE208CE3, ALU_BEQ, 32'hFFFFFFF8, 5'd0, OP_TYPE_REG,  OP_TYPE_REG,  0, 0, 0, 0));
        vecs.push_back(mk("jal",    32'h001000EF, ALU_JAL, 32'h800,      5'd1, OP_TYPE_PC,   OP_TYPE_IMM,  1, 0, 0, 0));
        vecs.push_back(mk("badf7",  32'h042081B3, ALU_NOP, 32'h0,        5'd3, OP_TYPE_NONE, OP_TYPE_NONE, 0, 0, 0, 1));
        vecs.push_back(mk("jalr_f3",32'h000090E7, ALU_NOP, 32'h0,        5'd1, OP_TYPE_NONE, OP_TYPE_NONE, 0, 0, 0, 1));
        vecs.push_back(mk("br_f3",  32'h00002063, ALU_NOP, 32'h0,        5'd0, OP_TYPE_NONE, OP_TYPE_NONE, 0, 0, 0, 1));
`ifdef RV32M_EN
        vecs.push_back(mk("mul",    32'h027302B3, ALU_MUL, 32'h0,        5'd5, OP_TYPE_REG,  OP_TYPE_REG,  1, 0, 0, 0));
`else
        vecs.push_back(mk("mul",    32'h027302B3, ALU_NOP, 32'h0,        5'd5, OP_TYPE_NONE, OP_TYPE_NONE, 0, 0, 0, 1));
`endif

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_count",     count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal",   out_illegal, 0);
        chk("rst_uop_zero",  (out_uop == '0), 1);
        chk("rst_out_pc",    out_pc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  in_ready, 1);

        // Empty-to-out_valid latency: accepted at first edge, visible after second
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet",   out_valid, 0);
        chk("lat_count1",    count, 1);
        @(negedge clk);
        chk("lat_valid",     out_valid, 1);
        chk("lat_alu",       out_uop.alucode, ALU_ADD);
        chk("lat_rd",        out_uop.rd, 3);
        chk("lat_we",        out_uop.reg_we, 1);
        chk("lat_ill",       out_illegal, 0);
        chk("lat_pc",        out_pc, 32'h100);
        @(posedge clk); #1;

        // Table-driven decode vectors
        foreach (vecs[k]) begin
            push_hs(vecs[k].inst, 32'h400 + 32'(k) * 4, vecs[k].name);
            wait_out(ok);
            if (!ok) chk({vecs[k].name, "_out_timeout"}, 0, 1);
            else     check_vec(vecs[k], 32'h400 + 32'(k) * 4);
            @(posedge clk); #1;
        end

        // Back-pressure: fill output register + FIFO, extra beat must wait; then drain in order
        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++)
            push_hs(((k + 1) << 20) | 32'h93, 32'h1000 + k * 4, "bp_fill");
        fork
            push_hs(((DEPTH + 2) << 20) | 32'h93, 32'h1000 + (DEPTH + 1) * 4, "bp_extra");
            begin
                repeat (3) @(negedge clk);
                chk("bp_count_full", count, DEPTH);
                chk("bp_in_ready0",  in_ready, 0);
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_pc",    out_pc, 32'h1000);
                chk("bp_hold_imm",   out_uop.imm, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
                got = 0;
                for (int c = 0; c < 40 && got < DEPTH + 2; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("bp_order_pc",  out_pc, 32'h1000 + got * 4);
                        chk("bp_order_imm", out_uop.imm, got + 1);
                        got++;
                    end
                end
                chk("bp_drained", got, DEPTH + 2);
            end
        join
        @(posedge clk); #1;

        // Halt: ecall then two adds; only the halt uop leaves, stage freezes until flush
        in_valid = 1'b1; in_inst = 32'h00000073; in_pc = 32'h200;
        @(posedge clk); #1;
        in_inst = 32'h002081B3; in_pc = 32'h204;
        @(posedge clk); #1;
        in_inst = 32'h00308233; in_pc = 32'h208;
        @(negedge clk);
        chk("halt_valid",    out_valid, 1);
        chk("halt_flag",     out_uop.is_halt, 1);
        chk("halt_alu",      out_uop.alucode, ALU_NOP);
        chk("halt_we",       out_uop.reg_we, 0);
        chk("halt_pc",       out_pc, 32'h200);
        chk("halt_in_ready", in_ready, 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("halt_no_more_out", extra, 0);
        in_valid = 1'b0;
        chk("halt_count",    count, 1);
        chk("halt_stuck",    in_ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("halt_fl_count", count, 0);
        chk("halt_fl_valid", out_valid, 0);
        chk("halt_fl_run",   in_ready, 1);
        @(posedge clk); #1;
        push_hs(32'h002081B3, 32'h300, "post_halt");
        wait_out(ok);
        chk("post_halt_out", ok, 1);
        chk("post_halt_pc",  out_pc, 32'h300);
        @(posedge clk); #1;

        // Flush concurrent with push and consume at full FIFO
        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++)
            push_hs(32'h002081B3, 32'h500 + k * 4, "fl_fill");
        @(negedge clk);
        chk("fl_full", count, DEPTH);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h600; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_in_ready0", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_count0", count, 0);
        chk("fl_valid0", out_valid, 0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || count != 0) extra++;
        end
        chk("fl_nothing_accepted", extra, 0);

        // Asynchronous reset mid-operation drops buffered work immediately
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_hs(32'h002081B3, 32'h700, "rst_fill");
        push_hs(32'h002081B3, 32'h704, "rst_fill");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_pc",    out_pc, 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("arst_no_partial", extra, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
